// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the hazard/stall unit: register index
// width, the zero register, the MDU FSM state encoding and the bundled
// pipeline-control words (including the bubble/NOP insertion patterns).
package hazard_stall_unit_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    // One word carrying every pipeline control this unit drives.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic idex_bubble;
        logic exmem_bubble;
        logic ifid_flush;
        logic mdu_busy;
    } stall_ctrl_t;

    // Free-flowing pipeline, nothing inserted.
    localparam stall_ctrl_t CTRL_DEFAULT = '{pc_write: 1'b1, ifid_write: 1'b1,
        idex_write: 1'b1, idex_bubble: 1'b0, exmem_bubble: 1'b0,
        ifid_flush: 1'b0, mdu_busy: 1'b0};

    // MDU accepted in RUN: freeze front end, NOP into EX/MEM.
    localparam stall_ctrl_t CTRL_MDU_START = '{pc_write: 1'b0, ifid_write: 1'b0,
        idex_write: 1'b0, idex_bubble: 1'b0, exmem_bubble: 1'b1,
        ifid_flush: 1'b0, mdu_busy: 1'b0};

    // MDU still occupying EX: same freeze, busy flag raised.
    localparam stall_ctrl_t CTRL_MDU_BUSY = '{pc_write: 1'b0, ifid_write: 1'b0,
        idex_write: 1'b0, idex_bubble: 1'b0, exmem_bubble: 1'b1,
        ifid_flush: 1'b0, mdu_busy: 1'b1};

    // Taken branch: kill the IF/ID and ID instructions, PC takes the target.
    localparam stall_ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1,
        idex_write: 1'b1, idex_bubble: 1'b1, exmem_bubble: 1'b0,
        ifid_flush: 1'b1, mdu_busy: 1'b0};

    // Load-use: hold PC and IF/ID, NOP into ID/EX for one cycle.
    localparam stall_ctrl_t CTRL_LOAD_USE = '{pc_write: 1'b0, ifid_write: 1'b0,
        idex_write: 1'b1, idex_bubble: 1'b1, exmem_bubble: 1'b0,
        ifid_flush: 1'b0, mdu_busy: 1'b0};

endpackage

// File: rtl/hazard_stall_unit_load_use.sv
// Load-use RAW comparator. Flags an ID instruction that needs, as an ALU
// operand, the register a load in EX is about to write. A store that only
// depends on its rt data is exempt: the MEM-stage store-data forward covers it.
module load_use_detect
    import hazard_stall_unit_pkg::*;
(
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             uses_rt_id,
    input  logic             memwrite_id,
    input  logic [REG_W-1:0] dest_ex,
    input  logic             memread_ex,
    output logic             load_use
);

    logic rs_hit;
    logic rt_hit;

    // Pure comparator; writes to the zero register never create a hazard.
    always_comb begin
        rs_hit   = (dest_ex == rs_id);
        rt_hit   = (dest_ex == rt_id) && uses_rt_id && !memwrite_id;
        load_use = memread_ex && (dest_ex != REG_ZERO) && (rs_hit || rt_hit);
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard/stall unit: holds or flushes the front-end pipeline registers for
// load-use hazards, multi-cycle MDU occupancy of EX and taken branches, and
// counts cycles in which the PC was held.
// Priority: reset > MDU (start/busy) > branch flush > load-use.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 4,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        rs_id,
    input  logic [4:0]        rt_id,
    input  logic              uses_rt_id,
    input  logic              memwrite_id,
    input  logic [4:0]        dest_ex,
    input  logic              memread_ex,
    input  logic              mdu_start_ex,
    input  logic              branch_taken_ex,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_write,
    output logic              idex_bubble,
    output logic              exmem_bubble,
    output logic              ifid_flush,
    output logic              mdu_busy,
    output logic [PERF_W-1:0] stall_count
);

    // The start cycle is one stall cycle, BUSY supplies the other LATENCY-1.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PERF_W-1:0] stall_count_q;
    logic              load_use;
    stall_ctrl_t       ctrl;

    load_use_detect u_load_use (
        .rs_id       (rs_id),
        .rt_id       (rt_id),
        .uses_rt_id  (uses_rt_id),
        .memwrite_id (memwrite_id),
        .dest_ex     (dest_ex),
        .memread_ex  (memread_ex),
        .load_use    (load_use)
    );

    // State, MDU counter and perf counter; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!ctrl.pc_write) begin
                stall_count_q <= stall_count_q + PERF_W'(1);
            end
        end
    end

    // Next state: start in RUN, count down in BUSY, one settle cycle in DONE
    // where a still-asserted mdu_start_ex belongs to the finishing instruction.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mdu_start_ex) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Control outputs from state plus current inputs, in priority order.
    always_comb begin
        ctrl = CTRL_DEFAULT;
        case (state_q)
            ST_RUN: begin
                if (mdu_start_ex) begin
                    ctrl = CTRL_MDU_START;
                end else if (branch_taken_ex) begin
                    ctrl = CTRL_FLUSH;
                end else if (load_use) begin
                    ctrl = CTRL_LOAD_USE;
                end
            end
            ST_BUSY: ctrl = CTRL_MDU_BUSY;
            ST_DONE: ctrl = CTRL_DEFAULT;
            default: ctrl = CTRL_DEFAULT;
        endcase
    end

    assign pc_write     = ctrl.pc_write;
    assign ifid_write   = ctrl.ifid_write;
    assign idex_write   = ctrl.idex_write;
    assign idex_bubble  = ctrl.idex_bubble;
    assign exmem_bubble = ctrl.exmem_bubble;
    assign ifid_flush   = ctrl.ifid_flush;
    assign mdu_busy     = ctrl.mdu_busy;
    assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model of the stall rules.
module tb_hazard_stall_unit;

    localparam int LAT = 4;

    // Clock and reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  rs_id, rt_id, dest_ex;
    logic        uses_rt_id, memwrite_id, memread_ex, mdu_start_ex, branch_taken_ex;
    logic        pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble;
    logic        ifid_flush, mdu_busy;
    logic [31:0] stall_count;

    hazard_stall_unit #(.MDU_LATENCY(LAT), .CNT_W(4), .PERF_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .rs_id           (rs_id),
        .rt_id           (rt_id),
        .uses_rt_id      (uses_rt_id),
        .memwrite_id     (memwrite_id),
        .dest_ex         (dest_ex),
        .memread_ex      (memread_ex),
        .mdu_start_ex    (mdu_start_ex),
        .branch_taken_ex (branch_taken_ex),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .idex_write      (idex_write),
        .idex_bubble     (idex_bubble),
        .exmem_bubble    (exmem_bubble),
        .ifid_flush      (ifid_flush),
        .mdu_busy        (mdu_busy),
        .stall_count     (stall_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model. Expected control word bit order:
    // {pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble, ifid_flush, mdu_busy}
    localparam logic [6:0] V_DEF   = 7'b1110000;
    localparam logic [6:0] V_START = 7'b0000100;
    localparam logic [6:0] V_BUSY  = 7'b0000101;
    localparam logic [6:0] V_FLUSH = 7'b1111010;
    localparam logic [6:0] V_LU    = 7'b0011000;

    logic [6:0]  exp_q[$];
    bit          m_active;   // an MDU op has been accepted and still occupies EX
    int          m_elapsed;  // stall cycles already spent on it
    bit          m_settle;   // cycle after the MDU finishes: start is ignored
    logic [31:0] m_stall;

    function automatic bit model_load_use();
        bit needs_rs, needs_rt;
        needs_rs = (rs_id == dest_ex);
        needs_rt = uses_rt_id && !memwrite_id && (rt_id == dest_ex);
        return memread_ex && (dest_ex != 5'd0) && (needs_rs || needs_rt);
    endfunction

    // Driver: apply one set of ID/EX inputs
    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                          input logic mw, input logic [4:0] dst, input logic mr,
                          input logic mdu, input logic br);
        rs_id = rs; rt_id = rt; uses_rt_id = urt; memwrite_id = mw;
        dest_ex = dst; memread_ex = mr; mdu_start_ex = mdu; branch_taken_ex = br;
    endtask

    // One clock: check outputs on the falling edge against the model, advance model.
    task automatic cycle();
        logic [6:0] exp_v, got_v;
        @(negedge clk);
        check_val("stall_count", stall_count, m_stall);
        if (rst) begin
            if (m_active) begin
                exp_v = V_BUSY;
                m_elapsed++;
                if (m_elapsed >= LAT) begin
                    m_active = 0;
                    m_settle = 1;
                end
            end else if (m_settle) begin
                exp_v = V_DEF;
                m_settle = 0;
            end else if (mdu_start_ex) begin
                exp_v = V_START;
                m_active = 1;
                m_elapsed = 1;
            end else if (branch_taken_ex) begin
                exp_v = V_FLUSH;
            end else if (model_load_use()) begin
                exp_v = V_LU;
            end else begin
                exp_v = V_DEF;
            end
            exp_q.push_back(exp_v);
            exp_v = exp_q.pop_front();
            got_v = {pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble, ifid_flush, mdu_busy};
            check_val("pc_write", got_v[6], exp_v[6]);
            check_val("ifid_write", got_v[5], exp_v[5]);
            check_val("idex_write", got_v[4], exp_v[4]);
            check_val("idex_bubble", got_v[3], exp_v[3]);
            check_val("exmem_bubble", got_v[2], exp_v[2]);
            check_val("ifid_flush", got_v[1], exp_v[1]);
            check_val("mdu_busy", got_v[0], exp_v[0]);
            if (!exp_v[6]) m_stall = m_stall + 32'd1;
        end else begin
            m_active = 0;
            m_settle = 0;
            m_stall  = '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        cycle();
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        idle();
        m_active = 0; m_settle = 0; m_elapsed = 0; m_stall = '0;
        @(posedge clk);
        #1;
        do_reset();
        do_reset();

        // Reset state
        #1;
        check_val("rst_pc_write", pc_write, 1);
        check_val("rst_idex_write", idex_write, 1);
        check_val("rst_mdu_busy", mdu_busy, 0);
        check_val("rst_stall_count", stall_count, 0);
        cycle();

        // Load-use on rs
        do_reset();
        set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        rs_id = 5'd8;
        #1;
        check_val("lu_rs_pc", pc_write, 0);
        check_val("lu_rs_bubble", idex_bubble, 1);
        cycle();
        idle();
        #1;
        check_val("lu_rs_after_pc", pc_write, 1);
        cycle();
        check_val("lu_rs_count", stall_count, 1);

        // Store exemption, then same store also reading rs
        do_reset();
        set_in(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        #1;
        check_val("store_exempt_pc", pc_write, 1);
        cycle();
        rs_id = 5'd9;
        #1;
        check_val("store_rs_pc", pc_write, 0);
        cycle();
        idle();
        cycle();
        check_val("store_count", stall_count, 1);

        // Zero register
        do_reset();
        set_in(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        check_val("zero_reg_pc", pc_write, 1);
        cycle();
        idle();
        cycle();
        check_val("zero_reg_count", stall_count, 0);

        // MDU occupancy: start + busy cycles, then DONE ignores the held start
        do_reset();
        for (int i = 0; i < LAT + 1; i++) begin
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            #1;
            check_val("mdu_pc_write", pc_write, (i < LAT) ? 0 : 1);
            check_val("mdu_exmem_bubble", exmem_bubble, (i < LAT) ? 1 : 0);
            check_val("mdu_busy_flag", mdu_busy, (i >= 1 && i < LAT) ? 1 : 0);
            cycle();
        end
        idle();
        cycle();
        check_val("mdu_count", stall_count, LAT);

        // Branch beats load-use
        do_reset();
        set_in(5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1);
        #1;
        check_val("br_flush", ifid_flush, 1);
        check_val("br_bubble", idex_bubble, 1);
        check_val("br_pc_write", pc_write, 1);
        check_val("br_ifid_write", ifid_write, 1);
        cycle();
        idle();
        cycle();
        check_val("br_count", stall_count, 0);

        // Reset on the second BUSY cycle
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        idle();
        #1;
        check_val("rst_busy_mdu_busy", mdu_busy, 0);
        check_val("rst_busy_count", stall_count, 0);
        check_val("rst_busy_pc_write", pc_write, 1);
        cycle();

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst             = ($urandom_range(0, 149) != 0);
            rs_id           = 5'($urandom_range(0, 3));
            rt_id           = 5'($urandom_range(0, 3));
            dest_ex         = 5'($urandom_range(0, 3));
            uses_rt_id      = 1'($urandom_range(0, 1));
            memwrite_id     = 1'($urandom_range(0, 1));
            memread_ex      = 1'($urandom_range(0, 1));
            mdu_start_ex    = ($urandom_range(0, 9) == 0);
            branch_taken_ex = ($urandom_range(0, 7) == 0);
            cycle();
        end
        rst = 1'b1;
        idle();
        for (int n = 0; n < LAT + 2; n++) cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
